// File: rtl/tl_ul_sram_slave_if.sv
// Bundles the TileLink-UL Channel A and Channel D signals of one link.
//   master modport: drives Channel A and d_ready; receives a_ready and Channel D.
//   slave modport : receives Channel A and d_ready; drives a_ready and Channel D.
// a_source, d_source and d_sink are single-bit ids.
interface tl_ul_sram_slave_if #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int MASK_WIDTH   = DATA_WIDTH / 8,
  parameter int SIZE_WIDTH   = 3,
  parameter int OPCODE_WIDTH = 3,
  parameter int PARAM_WIDTH  = 3
);
  // Channel A
  logic                    a_valid;
  logic                    a_ready;
  logic [OPCODE_WIDTH-1:0] a_opcode;
  logic [PARAM_WIDTH-1:0]  a_param;
  logic [SIZE_WIDTH-1:0]   a_size;
  logic                    a_source;
  logic [ADDR_WIDTH-1:0]   a_address;
  logic [MASK_WIDTH-1:0]   a_mask;
  logic [DATA_WIDTH-1:0]   a_data;
  // Channel D
  logic                    d_valid;
  logic                    d_ready;
  logic [OPCODE_WIDTH-1:0] d_opcode;
  logic [PARAM_WIDTH-1:0]  d_param;
  logic [SIZE_WIDTH-1:0]   d_size;
  logic                    d_source;
  logic                    d_sink;
  logic [DATA_WIDTH-1:0]   d_data;
  logic                    d_error;

  modport master (
    output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data,
    input  a_ready,
    input  d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_data, d_error,
    output d_ready
  );

  modport slave (
    input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data,
    output a_ready,
    output d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_data, d_error,
    input  d_ready
  );
endinterface

// File: rtl/tl_ul_sram_slave.sv
// TileLink-UL responder backed by an internal word memory.
// Accepts one Channel A request at a time (Get, PutFullData, PutPartialData).
// It answers each request with exactly one Channel D response, RESP_LATENCY cycles after the accept edge.
// Illegal requests (bad opcode, size > 4 bytes, misaligned, outside the window) get d_error=1.
// Such requests never touch memory.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset; clears FSM, counter and all d_* outputs
//   bus   : tl_ul_sram_slave_if.slave (Channel A in, Channel D out)
module tl_ul_sram_slave #(
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    MASK_WIDTH   = DATA_WIDTH / 8,
  parameter int                    SIZE_WIDTH   = 3,
  parameter int                    OPCODE_WIDTH = 3,
  parameter int                    PARAM_WIDTH  = 3,
  parameter int                    DEPTH        = 256,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0,
  parameter int                    RESP_LATENCY = 1
) (
  input  logic clk,
  input  logic reset,
  tl_ul_sram_slave_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [3:0] LAT_M1 = 4'(RESP_LATENCY - 1);
  // Window bounds carry one extra bit so a window ending at the top of the address space cannot wrap.
  localparam logic [ADDR_WIDTH:0] WIN_LO = {1'b0, BASE_ADDR};
  localparam logic [ADDR_WIDTH:0] WIN_HI = WIN_LO + (ADDR_WIDTH + 1)'(4 * DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t state_reg, state_next;
  logic [3:0] cnt_reg, cnt_next;

  logic [OPCODE_WIDTH-1:0] resp_opcode_reg;
  logic                    resp_error_reg;
  logic [SIZE_WIDTH-1:0]   resp_size_reg;
  logic                    resp_source_reg;
  logic                    resp_rd_ok_reg;

  logic                    accept;
  logic                    op_get, op_put, op_bad;
  logic                    size_bad, misaligned, out_of_range, req_error;
  logic [ADDR_WIDTH:0]     addr_ext;
  logic [ADDR_WIDTH-1:0]   offset;
  logic [IDX_W-1:0]        word_idx;
  logic                    wr_en, rd_en;
  logic [DATA_WIDTH-1:0]   rd_word;
  logic                    unused_bits;

  // a_ready drops while reset is asserted, even though the state register already reads IDLE.
  assign bus.a_ready = (state_reg == ST_IDLE) && reset;
  assign accept      = bus.a_valid && bus.a_ready;

  // ---------------- request decode ----------------
  assign op_get = (bus.a_opcode == OPCODE_WIDTH'(4));
  assign op_put = (bus.a_opcode == OPCODE_WIDTH'(0)) || (bus.a_opcode == OPCODE_WIDTH'(1));
  assign op_bad = !(op_get || op_put);

  assign size_bad = (bus.a_size > SIZE_WIDTH'(2));

  always_comb begin
    misaligned = 1'b0;
    case (bus.a_size)
      SIZE_WIDTH'(1): misaligned = bus.a_address[0];
      SIZE_WIDTH'(2): misaligned = |bus.a_address[1:0];
      default:        misaligned = 1'b0;
    endcase
  end

  assign addr_ext     = {1'b0, bus.a_address};
  assign out_of_range = (addr_ext < WIN_LO) || (addr_ext >= WIN_HI);
  assign req_error    = op_bad || size_bad || misaligned || out_of_range;

  assign offset   = bus.a_address - BASE_ADDR;
  assign word_idx = offset[IDX_W+1:2];

  assign wr_en = accept && op_put && !req_error;
  assign rd_en = accept && op_get && !req_error;

  // ---------------- memory: one byte-wide array per lane ----------------
  // Separate lane arrays map directly onto byte-enabled block RAM. The read
  // register loads only on a good Get, so it holds steady while a response waits.
  genvar gi;
  generate
    for (gi = 0; gi < MASK_WIDTH; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH];
      logic [7:0] lane_rd_reg;

      always_ff @(posedge clk) begin
        if (wr_en && bus.a_mask[gi]) begin
          lane_mem[word_idx] <= bus.a_data[gi*8 +: 8];
        end
        if (rd_en) begin
          lane_rd_reg <= lane_mem[word_idx];
        end
      end

      assign rd_word[gi*8 +: 8] = lane_rd_reg;
    end
  endgenerate

  // ---------------- FSM and response registers ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg       <= ST_IDLE;
      cnt_reg         <= '0;
      resp_opcode_reg <= '0;
      resp_error_reg  <= 1'b0;
      resp_size_reg   <= '0;
      resp_source_reg <= 1'b0;
      resp_rd_ok_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (accept) begin
        // Get answers AccessAckData even when rejected; everything else answers AccessAck.
        resp_opcode_reg <= op_get ? OPCODE_WIDTH'(1) : OPCODE_WIDTH'(0);
        resp_error_reg  <= req_error;
        resp_size_reg   <= bus.a_size;
        resp_source_reg <= bus.a_source;
        resp_rd_ok_reg  <= rd_en;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          state_next = ST_WAIT;
          cnt_next   = LAT_M1;
        end
      end
      ST_WAIT: begin
        if (cnt_reg == 4'd0) begin
          state_next = ST_RESP;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      ST_RESP: begin
        if (bus.d_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign bus.d_valid  = (state_reg == ST_RESP);
  assign bus.d_opcode = resp_opcode_reg;
  assign bus.d_param  = '0;
  assign bus.d_size   = resp_size_reg;
  assign bus.d_source = resp_source_reg;
  assign bus.d_sink   = 1'b0;
  assign bus.d_error  = resp_error_reg;
  // Read data only surfaces for a successful Get; the gate also hides the unreset RAM output.
  assign bus.d_data   = resp_rd_ok_reg ? rd_word : '0;

  // a_param is ignored by this responder; offset bits outside the word index are irrelevant.
  assign unused_bits = ^{bus.a_param, offset};

endmodule
